lcd_msg_scheduler: RTL and testbench

- Shares the single two-line 16x2 LCD text path between N_REQ message sources, such as the effect menu, level meter and status banners.
- Sits in front of the LCD string writer. It drives that writer's two 16-byte string inputs and consumes its end-of-refresh pulse.
- Arbitration is round-robin with an urgent override and a minimum on-screen hold time.
- Content switches only at refresh boundaries, so the display never tears.

---
 rtl/lcd_pkg.sv | 21 ++
 rtl/lcd_msg_scheduler_if.sv | 37 +++
 rtl/lcd_rr_pick.sv | 42 ++++
 rtl/lcd_msg_scheduler.sv | 147 ++++++++++++++
 tb/tb_lcd_msg_scheduler.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD message scheduler slice.
//   LCD_COLS      : characters per display line
//   lcd_char_t    : one display character code
//   lcd_line_t    : one full 16-character line, element 0 is the leftmost column
//   BLANK_LINE    : a line of spaces
//   sched_state_t : scheduler ownership state (IDLE, SHOW)
package lcd_pkg;

  localparam int LCD_COLS = 16;

  typedef logic [7:0] lcd_char_t;
  typedef lcd_char_t [0:LCD_COLS-1] lcd_line_t;

  localparam lcd_line_t BLANK_LINE = {LCD_COLS{8'h20}};

  typedef enum logic {
    IDLE = 1'b0,
    SHOW = 1'b1
  } sched_state_t;

endpackage

// File: rtl/lcd_msg_scheduler_if.sv
// Bundle between the message sources, the LCD string writer and the scheduler.
//   iReq/iUrgent          : per-source level request and urgency qualifier
//   iString0/iString1     : per-source line-1 / line-2 text
//   iFrameDone            : end-of-refresh pulse from the string writer
//   oString0/oString1     : registered text buffers feeding the writer
//   oGrant/oOwner         : one-hot owner and binary index of current/last owner
//   oSwitch/oBusy         : ownership-load pulse and "screen owned" flag
// Modports: master = sources/writer side, slave = scheduler side.
interface lcd_msg_scheduler_if #(
  parameter int N_REQ = 4
);
  import lcd_pkg::*;

  logic [N_REQ-1:0]      iReq;
  logic [N_REQ-1:0]      iUrgent;
  lcd_line_t [0:N_REQ-1] iString0;
  lcd_line_t [0:N_REQ-1] iString1;
  logic                  iFrameDone;

  lcd_line_t             oString0;
  lcd_line_t             oString1;
  logic [N_REQ-1:0]      oGrant;
  logic [2:0]            oOwner;
  logic                  oSwitch;
  logic                  oBusy;

  modport master (
    output iReq, iUrgent, iString0, iString1, iFrameDone,
    input  oString0, oString1, oGrant, oOwner, oSwitch, oBusy
  );

  modport slave (
    input  iReq, iUrgent, iString0, iString1, iFrameDone,
    output oString0, oString1, oGrant, oOwner, oSwitch, oBusy
  );

endinterface

// File: rtl/lcd_rr_pick.sv
// Combinational rotating-priority picker.
//   req    : candidate vector
//   urgent : urgency mask; if any candidate is urgent only urgent ones compete
//   ptr    : index where the circular search starts
//   win    : first eligible index at or after ptr (wrapping)
//   valid  : high when any candidate exists
module lcd_rr_pick #(
  parameter int N_REQ = 4,
  parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] urgent,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] win,
  output logic             valid
);

  localparam int IW1 = IDX_W + 1;

  logic [N_REQ-1:0] pool;
  logic [IW1-1:0]   idx;

  // Urgent candidates shadow everyone else; the scan walks the pool
  // circularly from ptr and keeps the first hit.
  always_comb begin
    pool  = ((req & urgent) != '0) ? (req & urgent) : req;
    win   = '0;
    valid = 1'b0;
    idx   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = {1'b0, ptr} + IW1'(i);
      if (idx >= IW1'(N_REQ)) begin
        idx = idx - IW1'(N_REQ);
      end
      if (!valid && pool[idx[IDX_W-1:0]]) begin
        valid = 1'b1;
        win   = idx[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/lcd_msg_scheduler.sv
// Shares the two-line LCD text path between N_REQ message sources.
// Ownership changes only on the writer's end-of-refresh pulse (except the
// first grant from IDLE), so the writer never shows a mix of two sources.
//   iCLK_50 : 50 MHz clock
//   iRST_N  : asynchronous active-low reset
//   bus     : scheduler side of lcd_msg_scheduler_if (see interface header)
module lcd_msg_scheduler #(
  parameter int         N_REQ       = 4,
  parameter int         HOLD_FRAMES = 8,
  parameter logic [7:0] BLANK_CHAR  = 8'h20
) (
  input  logic               iCLK_50,
  input  logic               iRST_N,
  lcd_msg_scheduler_if.slave bus
);
  import lcd_pkg::*;

  localparam int        IDX_W     = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam lcd_line_t FILL_LINE = {LCD_COLS{BLANK_CHAR}};

  sched_state_t     state_q, state_d;
  lcd_line_t        str0_q, str0_d;
  lcd_line_t        str1_q, str1_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             switch_q, switch_d;

  logic [N_REQ-1:0] cand;
  logic [IDX_W-1:0] win;
  logic             win_valid;
  logic             owner_req;
  logic             owner_urg;
  logic             urgent_other;
  logic [8:0]       cnt_inc;
  logic             hold_hit;
  logic             load;

  // While showing, the current owner is not a candidate against itself.
  always_comb begin
    cand         = (state_q == SHOW) ? (bus.iReq & ~grant_q) : bus.iReq;
    owner_req    = bus.iReq[owner_q];
    owner_urg    = owner_req & bus.iUrgent[owner_q];
    urgent_other = |(cand & bus.iUrgent);
    cnt_inc      = {1'b0, cnt_q} + 9'd1;
    hold_hit     = cnt_inc >= 9'(HOLD_FRAMES);
  end

  lcd_rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req    (cand),
    .urgent (bus.iUrgent),
    .ptr    (ptr_q),
    .win    (win),
    .valid  (win_valid)
  );

  // Next-state logic. In SHOW nothing moves except on iFrameDone; the
  // decision order is urgent preempt, owner release, hold expiry, then
  // live refresh of the owner's text. Any ownership load is applied last.
  always_comb begin
    state_d  = state_q;
    str0_d   = str0_q;
    str1_d   = str1_q;
    grant_d  = grant_q;
    owner_d  = owner_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    switch_d = 1'b0;
    load     = 1'b0;

    case (state_q)
      IDLE: begin
        if (|bus.iReq) begin
          load = 1'b1;
        end
      end
      SHOW: begin
        if (bus.iFrameDone) begin
          if (urgent_other && !owner_urg) begin
            load = 1'b1;
          end else if (!owner_req) begin
            if (win_valid) begin
              load = 1'b1;
            end else begin
              state_d = IDLE;
              grant_d = '0;
            end
          end else if (hold_hit && win_valid) begin
            load = 1'b1;
          end else begin
            str0_d = bus.iString0[owner_q];
            str1_d = bus.iString1[owner_q];
            cnt_d  = hold_hit ? 8'(HOLD_FRAMES) : cnt_q + 8'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      state_d       = SHOW;
      str0_d        = bus.iString0[win];
      str1_d        = bus.iString1[win];
      grant_d       = '0;
      grant_d[win]  = 1'b1;
      owner_d       = win;
      ptr_d         = (win == IDX_W'(N_REQ - 1)) ? '0 : win + IDX_W'(1);
      cnt_d         = '0;
      switch_d      = 1'b1;
    end
  end

  // State and output registers; reset blanks the writer immediately.
  always_ff @(posedge iCLK_50 or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q  <= IDLE;
      str0_q   <= FILL_LINE;
      str1_q   <= FILL_LINE;
      grant_q  <= '0;
      owner_q  <= '0;
      ptr_q    <= '0;
      cnt_q    <= '0;
      switch_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      str0_q   <= str0_d;
      str1_q   <= str1_d;
      grant_q  <= grant_d;
      owner_q  <= owner_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      switch_q <= switch_d;
    end
  end

  assign bus.oString0 = str0_q;
  assign bus.oString1 = str1_q;
  assign bus.oGrant   = grant_q;
  assign bus.oOwner   = 3'(owner_q);
  assign bus.oSwitch  = switch_q;
  assign bus.oBusy    = (state_q == SHOW);

endmodule

// File: tb/tb_lcd_msg_scheduler.sv
// Self-checking bench for lcd_msg_scheduler: directed scenarios followed by a
// randomized phase, every cycle compared against a behavioural model of the
// ownership rules (who owns the screen, what text it shows, hold count).
module tb_lcd_msg_scheduler;
  import lcd_pkg::*;

  localparam int N    = 4;
  localparam int HOLD = 8;
  localparam int IW   = $clog2(N);

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  lcd_msg_scheduler_if #(.N_REQ(N)) bus ();

  lcd_msg_scheduler #(
    .N_REQ       (N),
    .HOLD_FRAMES (HOLD),
    .BLANK_CHAR  (8'h20)
  ) dut (
    .iCLK_50 (clk),
    .iRST_N  (rst_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog expired before end of test");
    $fatal(1, "[TB] watchdog");
  end

  // Reference model state
  bit            m_busy;
  logic [IW-1:0] m_owner;
  logic [IW-1:0] m_ptr;
  int            m_cnt;
  lcd_line_t     m_str0;
  lcd_line_t     m_str1;
  bit            m_switch;

  function automatic lcd_line_t make_line(input string s);
    lcd_line_t l;
    l = BLANK_LINE;
    for (int i = 0; i < LCD_COLS && i < s.len(); i++) l[i] = s[i];
    return l;
  endfunction

  function automatic lcd_line_t rand_line();
    lcd_line_t l;
    for (int i = 0; i < LCD_COLS; i++) l[i] = 8'($urandom_range(33, 126));
    return l;
  endfunction

  function automatic logic [N-1:0] onehot(input logic [IW-1:0] i);
    logic [N-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  // First eligible source scanning circularly from start; urgent ones first.
  function automatic logic [IW-1:0] model_pick(input logic [N-1:0] cand,
                                               input logic [N-1:0] urg,
                                               input logic [IW-1:0] start);
    logic [N-1:0]  pool;
    logic [IW-1:0] idx;
    pool = ((cand & urg) != '0) ? (cand & urg) : cand;
    for (int k = 0; k < N; k++) begin
      idx = IW'((int'(start) + k) % N);
      if (pool[idx]) return idx;
    end
    return '0;
  endfunction

  task automatic model_reset();
    m_busy   = 1'b0;
    m_owner  = '0;
    m_ptr    = '0;
    m_cnt    = 0;
    m_str0   = BLANK_LINE;
    m_str1   = BLANK_LINE;
    m_switch = 1'b0;
  endtask

  task automatic model_edge();
    logic [N-1:0]  req;
    logic [N-1:0]  urg;
    logic [N-1:0]  cand;
    logic [IW-1:0] w;
    bit            load;
    req      = bus.iReq;
    urg      = bus.iUrgent;
    cand     = req;
    load     = 1'b0;
    m_switch = 1'b0;
    if (!m_busy) begin
      load = (req != '0);
    end else if (bus.iFrameDone) begin
      cand = req & ~onehot(m_owner);
      if ((cand & urg) != '0 && !(req[m_owner] && urg[m_owner])) begin
        load = 1'b1;
      end else if (!req[m_owner]) begin
        if (cand != '0) load = 1'b1;
        else m_busy = 1'b0;
      end else if (m_cnt + 1 >= HOLD && cand != '0) begin
        load = 1'b1;
      end else begin
        m_str0 = bus.iString0[m_owner];
        m_str1 = bus.iString1[m_owner];
        m_cnt  = (m_cnt + 1 > HOLD) ? HOLD : m_cnt + 1;
      end
    end
    if (load) begin
      w        = model_pick(cand, urg, m_ptr);
      m_busy   = 1'b1;
      m_owner  = w;
      m_str0   = bus.iString0[w];
      m_str1   = bus.iString1[w];
      m_switch = 1'b1;
      m_cnt    = 0;
      m_ptr    = IW'((int'(w) + 1) % N);
    end
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_output(input string phase);
    logic [N-1:0] exp_grant;
    exp_grant = m_busy ? onehot(m_owner) : '0;
    check({phase, ".grant"},  128'(bus.oGrant),   128'(exp_grant));
    check({phase, ".owner"},  128'(bus.oOwner),   128'(m_owner));
    check({phase, ".switch"}, 128'(bus.oSwitch),  128'(m_switch));
    check({phase, ".busy"},   128'(bus.oBusy),    128'(m_busy));
    check({phase, ".str0"},   128'(bus.oString0), 128'(m_str0));
    check({phase, ".str1"},   128'(bus.oString1), 128'(m_str1));
  endtask

  task automatic apply_stimulus(input logic [N-1:0] req, input logic [N-1:0] urg, input logic fd);
    bus.iReq       = req;
    bus.iUrgent    = urg;
    bus.iFrameDone = fd;
  endtask

  task automatic tick(input string phase);
    @(posedge clk);
    if (rst_n) model_edge();
    else model_reset();
    @(negedge clk);
    check_output(phase);
  endtask

  task automatic frame(input int gap, input string phase);
    for (int i = 0; i < gap - 1; i++) tick(phase);
    bus.iFrameDone = 1'b1;
    tick(phase);
    bus.iFrameDone = 1'b0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    model_reset();
    apply_stimulus('0, '0, 1'b0);
    tick("reset");
    tick("reset");
    check("reset.str0_blank", 128'(bus.oString0), 128'(BLANK_LINE));
    check("reset.str1_blank", 128'(bus.oString1), 128'(BLANK_LINE));
    check("reset.grant_zero", 128'(bus.oGrant), 128'(0));
    check("reset.busy_zero",  128'(bus.oBusy), 128'(0));
    rst_n = 1'b1;
  endtask

  initial begin
    logic [1:0] src;

    checks = 0;
    errors = 0;
    rst_n  = 1'b1;
    apply_stimulus('0, '0, 1'b0);
    bus.iString0[0] = make_line("HELLO");  bus.iString1[0] = make_line("WORLD");
    bus.iString0[1] = make_line("MENU");   bus.iString1[1] = make_line("EFFECT");
    bus.iString0[2] = make_line("ALERT");  bus.iString1[2] = make_line("CLIP");
    bus.iString0[3] = make_line("LEVEL");  bus.iString1[3] = make_line("-12dB");
    #1;
    apply_reset();

    // Requester 0 alone: granted one cycle after request
    apply_stimulus(4'b0001, 4'b0000, 1'b0);
    tick("hello");
    check("hello.grant",  128'(bus.oGrant), 128'(4'b0001));
    check("hello.str0",   128'(bus.oString0), 128'(make_line("HELLO")));
    check("hello.switch", 128'(bus.oSwitch), 128'(1));
    check("hello.busy",   128'(bus.oBusy), 128'(1));
    tick("hello");
    check("hello.switch_drop", 128'(bus.oSwitch), 128'(0));

    // Hold time: source 1 waits exactly HOLD refreshes
    apply_stimulus(4'b0011, 4'b0000, 1'b0);
    for (int p = 1; p <= HOLD; p++) begin
      frame(100, "hold");
      if (p < HOLD) check("hold.keep", 128'(bus.oGrant), 128'(4'b0001));
      else          check("hold.move", 128'(bus.oGrant), 128'(4'b0010));
    end

    // Round-robin fairness with everyone requesting
    apply_reset();
    apply_stimulus(4'b1111, 4'b0000, 1'b0);
    tick("rr");
    check("rr.first", 128'(bus.oOwner), 128'(0));
    for (int sw = 1; sw <= 4; sw++) begin
      for (int p = 1; p <= HOLD; p++) begin
        frame(20, "rr");
        if (p == HOLD - 1) check("rr.hold", 128'(bus.oOwner), 128'((sw - 1) % 4));
      end
      check("rr.order", 128'(bus.oOwner), 128'(sw % 4));
    end

    // Urgent preempt ignores the hold count; buffer frozen between pulses
    apply_reset();
    apply_stimulus(4'b0001, 4'b0000, 1'b0);
    tick("urg");
    frame(10, "urg");
    frame(10, "urg");
    apply_stimulus(4'b0101, 4'b0100, 1'b0);
    bus.iString0[0] = make_line("CHANGED");
    for (int i = 0; i < 5; i++) tick("urg");
    check("urg.before_grant", 128'(bus.oGrant), 128'(4'b0001));
    check("urg.before_str0",  128'(bus.oString0), 128'(make_line("HELLO")));
    frame(10, "urg");
    check("urg.after_grant", 128'(bus.oGrant), 128'(4'b0100));
    check("urg.after_owner", 128'(bus.oOwner), 128'(2));
    bus.iString0[0] = make_line("HELLO");

    // Release to idle keeps text and last owner
    apply_reset();
    apply_stimulus(4'b0010, 4'b0000, 1'b0);
    tick("rel");
    frame(10, "rel");
    apply_stimulus(4'b0000, 4'b0000, 1'b0);
    for (int i = 0; i < 3; i++) tick("rel");
    check("rel.still_granted", 128'(bus.oGrant), 128'(4'b0010));
    frame(10, "rel");
    check("rel.grant", 128'(bus.oGrant), 128'(0));
    check("rel.busy",  128'(bus.oBusy), 128'(0));
    check("rel.owner", 128'(bus.oOwner), 128'(1));
    check("rel.str0",  128'(bus.oString0), 128'(make_line("MENU")));

    // Randomized traffic against the model
    for (int t = 0; t < 600; t++) begin
      if ($urandom_range(0, 7) == 0) begin
        src = 2'($urandom_range(0, 3));
        bus.iString0[src] = rand_line();
        bus.iString1[src] = rand_line();
      end
      if ($urandom_range(0, 5) == 0) begin
        bus.iReq    = 4'($urandom);
        bus.iUrgent = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
      end
      bus.iFrameDone = ($urandom_range(0, 2) == 0);
      tick("rand");
    end

    // Asynchronous reset in the middle of a frame
    apply_stimulus(4'b0001, 4'b0000, 1'b0);
    tick("midrst");
    tick("midrst");
    @(posedge clk);
    model_edge();
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("midrst.str0",  128'(bus.oString0), 128'(BLANK_LINE));
    check("midrst.str1",  128'(bus.oString1), 128'(BLANK_LINE));
    check("midrst.grant", 128'(bus.oGrant), 128'(0));
    check("midrst.busy",  128'(bus.oBusy), 128'(0));
    check_output("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    tick("post");
    tick("post");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
